// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 pixel path: RGB pixel layout,
// byte-order indices and the SPI receive state encoding.
package ws2812_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam logic [1:0] COLOR_R = 2'd0;
  localparam logic [1:0] COLOR_G = 2'd1;
  localparam logic [1:0] COLOR_B = 2'd2;

  localparam int BYTES_PER_PIXEL = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_STORE
  } rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and derives the
// single-cycle edge strobes used by the receive FSM.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic cs_n_i,
  output logic sclk_rise_o,
  output logic mosi_s_o,
  output logic cs_n_s_o,
  output logic cs_rise_o,
  output logic cs_fall_o
);

  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [2:0] cs_q;

  // cs_n powers up deasserted so no false transaction start follows reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
      cs_q   <= 3'b111;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      mosi_q <= {mosi_q[0], mosi_i};
      cs_q   <= {cs_q[1:0], cs_n_i};
    end
  end

  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign mosi_s_o    = mosi_q[1];
  assign cs_n_s_o    = cs_q[1];
  assign cs_rise_o   = cs_q[1] & ~cs_q[2];
  assign cs_fall_o   = ~cs_q[1] & cs_q[2];

endmodule

// File: rtl/spi_pixel_buffer.sv
// Double-buffered pixel store: SPI writes fill the shadow bank, the LED
// driver reads the active bank, and banks swap only at a frame boundary.
module spi_pixel_buffer
  import ws2812_pkg::*;
#(
  parameter  int NUM_LEDS = 4,
  localparam int ADDR_W   = $clog2(NUM_LEDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  input  logic              data_request,
  input  logic [ADDR_W-1:0] address,
  output logic [7:0]        red_out,
  output logic [7:0]        green_out,
  output logic [7:0]        blue_out,
  output logic              frame_done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_LEDS - 1);
  localparam bit                ADDR_DENSE = ((1 << ADDR_W) == NUM_LEDS);

  logic sclk_rise, mosi_s, cs_n_s, cs_rise, cs_fall;

  spi_sync_edge u_sync (
    .clk         (clk),
    .reset       (reset),
    .sclk_i      (spi_sclk),
    .mosi_i      (spi_mosi),
    .cs_n_i      (spi_cs_n),
    .sclk_rise_o (sclk_rise),
    .mosi_s_o    (mosi_s),
    .cs_n_s_o    (cs_n_s),
    .cs_rise_o   (cs_rise),
    .cs_fall_o   (cs_fall)
  );

  rx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        color_cnt_q, color_cnt_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [7:0]        byte_sr_q, byte_sr_d;
  logic [7:0]        r_stage_q, r_stage_d;
  logic [7:0]        g_stage_q, g_stage_d;
  logic              frame_complete_q, frame_complete_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  logic              swap_pending_q, swap_pending_d;
  logic              bank_sel_q, bank_sel_d;
  pixel_t            rgb_q, rgb_d;
  pixel_t            bank_q [2][NUM_LEDS];

  logic   wr_en;
  pixel_t wr_data;
  logic   swap_set;
  logic   swap_now;
  logic   rd_bank;
  logic   addr_ok;

  always_comb begin
    state_d          = state_q;
    bit_cnt_d        = bit_cnt_q;
    color_cnt_d      = color_cnt_q;
    pix_addr_d       = pix_addr_q;
    byte_sr_d        = byte_sr_q;
    r_stage_d        = r_stage_q;
    g_stage_d        = g_stage_q;
    frame_complete_d = frame_complete_q;
    overflow_d       = overflow_q;
    frame_done_d     = 1'b0;
    wr_en            = 1'b0;
    wr_data          = '{r: r_stage_q, g: g_stage_q, b: byte_sr_q};
    swap_set         = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (!cs_n_s) begin
          state_d     = RX_SHIFT;
          bit_cnt_d   = 3'd0;
          color_cnt_d = COLOR_R;
          pix_addr_d  = '0;
          overflow_d  = 1'b0;
        end
      end
      RX_SHIFT: begin
        if (sclk_rise) begin
          byte_sr_d = {byte_sr_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_STORE;
        end
      end
      RX_STORE: begin
        state_d = RX_SHIFT;
        // Once a full frame is held, extra bytes only flag overflow
        if (frame_complete_q) begin
          overflow_d = 1'b1;
        end else begin
          case (color_cnt_q)
            COLOR_R: begin
              r_stage_d   = byte_sr_q;
              color_cnt_d = COLOR_G;
            end
            COLOR_G: begin
              g_stage_d   = byte_sr_q;
              color_cnt_d = COLOR_B;
            end
            default: begin
              wr_en       = 1'b1;
              pix_addr_d  = pix_addr_q + 1'b1;
              color_cnt_d = COLOR_R;
              if (pix_addr_q == LAST_ADDR) begin
                frame_complete_d = 1'b1;
                frame_done_d     = 1'b1;
              end
            end
          endcase
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (cs_fall) overflow_d = 1'b0;

    // End of transaction abandons partial data; a complete frame becomes pending
    if (cs_rise) begin
      state_d = RX_IDLE;
      if (frame_complete_d) begin
        swap_set         = 1'b1;
        frame_complete_d = 1'b0;
      end
    end
  end

  always_comb begin
    swap_now       = data_request && (address == '0) && swap_pending_q;
    bank_sel_d     = bank_sel_q ^ swap_now;
    swap_pending_d = (swap_pending_q && !swap_now) || swap_set;
    rd_bank        = bank_sel_q ^ swap_now;
    addr_ok        = ADDR_DENSE || ({{(32-ADDR_W){1'b0}}, address} < 32'(NUM_LEDS));
    rgb_d          = rgb_q;
    if (data_request) rgb_d = addr_ok ? bank_q[rd_bank][address] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RX_IDLE;
      bit_cnt_q        <= '0;
      color_cnt_q      <= COLOR_R;
      pix_addr_q       <= '0;
      byte_sr_q        <= '0;
      r_stage_q        <= '0;
      g_stage_q        <= '0;
      frame_complete_q <= 1'b0;
      overflow_q       <= 1'b0;
      frame_done_q     <= 1'b0;
      swap_pending_q   <= 1'b0;
      bank_sel_q       <= 1'b0;
      rgb_q            <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_LEDS; i++)
          bank_q[b][i] <= '0;
    end else begin
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      color_cnt_q      <= color_cnt_d;
      pix_addr_q       <= pix_addr_d;
      byte_sr_q        <= byte_sr_d;
      r_stage_q        <= r_stage_d;
      g_stage_q        <= g_stage_d;
      frame_complete_q <= frame_complete_d;
      overflow_q       <= overflow_d;
      frame_done_q     <= frame_done_d;
      swap_pending_q   <= swap_pending_d;
      bank_sel_q       <= bank_sel_d;
      rgb_q            <= rgb_d;
      if (wr_en) bank_q[~bank_sel_q][pix_addr_q] <= wr_data;
    end
  end

  assign red_out    = rgb_q.r;
  assign green_out  = rgb_q.g;
  assign blue_out   = rgb_q.b;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_spi_pixel_buffer.sv
// Scoreboard bench: SPI frames and driver reads are modelled as two pixel
// banks plus a pending flag; a monitor compares each read response.
module tb_spi_pixel_buffer;
  import ws2812_pkg::*;

  localparam int N           = 4;
  localparam int AW          = 2;
  localparam int FRAME_BYTES = N * BYTES_PER_PIXEL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_sclk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          data_request = 1'b0;
  logic [AW-1:0] address = '0;
  logic [7:0]    red_out, green_out, blue_out;
  logic          frame_done, overflow;

  spi_pixel_buffer #(.NUM_LEDS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_cs_n     (spi_cs_n),
    .data_request (data_request),
    .address      (address),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: two banks, which one is visible, and whether a swap waits
  logic [23:0]  mBank [2][N];
  int           mSel;
  bit           mPending;
  bit           mOverflow;
  logic [23:0]  lastExp;
  byte unsigned rxBytes[$];
  int           expFrames = 0;
  int           seenFrames = 0;
  logic [23:0]  expQ[$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with a request yields one response a cycle later
  initial begin
    forever begin
      @(posedge clk);
      if (data_request === 1'b1 && reset === 1'b0) begin
        #1;
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL read without expectation: got %0h", {red_out, green_out, blue_out});
        end else begin
          logic [23:0] e;
          e = expQ.pop_front();
          checkVal("pixel read", {8'h0, red_out, green_out, blue_out}, {8'h0, e});
        end
      end
    end
  end

  always @(negedge clk) if (frame_done === 1'b1) seenFrames++;

  task automatic resetModel();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++)
        mBank[b][i] = '0;
    mSel      = 0;
    mPending  = 1'b0;
    mOverflow = 1'b0;
    lastExp   = '0;
    rxBytes.delete();
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    reset    = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    resetModel();
  endtask

  task automatic spiBit(input bit b);
    spi_mosi = b;
    #40 spi_sclk = 1'b1;
    #40 spi_sclk = 1'b0;
  endtask

  task automatic spiByte(input byte unsigned v);
    for (int i = 7; i >= 0; i--) spiBit(v[i]);
    rxBytes.push_back(v);
    if (rxBytes.size() == FRAME_BYTES) expFrames++;
    if (rxBytes.size() > FRAME_BYTES) mOverflow = 1'b1;
  endtask

  task automatic csLow();
    spi_cs_n = 1'b0;
    #100;
    rxBytes.delete();
    mOverflow = 1'b0;
  endtask

  // Closing a transaction: complete pixels land in the shadow bank
  task automatic csHigh();
    int n, npix;
    #100;
    spi_cs_n = 1'b1;
    #100;
    n    = rxBytes.size();
    npix = ((n < FRAME_BYTES) ? n : FRAME_BYTES) / BYTES_PER_PIXEL;
    for (int p = 0; p < npix; p++)
      mBank[1-mSel][p] = {rxBytes[3*p], rxBytes[3*p+1], rxBytes[3*p+2]};
    if (n >= FRAME_BYTES) mPending = 1'b1;
  endtask

  task automatic applyStimulus(input int nBytes, input bit counting, input byte unsigned base);
    csLow();
    for (int i = 0; i < nBytes; i++)
      spiByte(counting ? byte'(base + i) : byte'($urandom_range(0, 255)));
    csHigh();
  endtask

  task automatic readPixel(input int a);
    @(negedge clk);
    data_request = 1'b1;
    address      = AW'(a);
    if (a == 0 && mPending) begin
      mSel     = 1 - mSel;
      mPending = 1'b0;
    end
    lastExp = (a < N) ? mBank[mSel][a] : 24'h0;
    expQ.push_back(lastExp);
    @(negedge clk);
    data_request = 1'b0;
  endtask

  task automatic checkOutput();
    #60;
    checkVal("frame_done pulses", 32'(seenFrames), 32'(expFrames));
    checkVal("overflow", {31'h0, overflow}, {31'h0, mOverflow});
    checkVal("output hold", {8'h0, red_out, green_out, blue_out}, {8'h0, lastExp});
  endtask

  initial begin
    resetModel();
    applyReset(4);
    checkOutput();
    for (int a = 0; a < N; a++) readPixel(a);

    applyStimulus(FRAME_BYTES, 1'b1, 8'h11);
    checkOutput();
    readPixel(0);
    readPixel(2);

    applyReset(3);
    applyStimulus(FRAME_BYTES, 1'b1, 8'h11);
    readPixel(1);
    readPixel(0);
    readPixel(1);
    checkOutput();

    applyStimulus(7, 1'b1, 8'h40);
    checkOutput();
    for (int a = 0; a < N; a++) readPixel(a);

    csLow();
    for (int i = 0; i < FRAME_BYTES; i++) spiByte(byte'(8'h60 + i));
    checkOutput();
    spiByte(8'hA5);
    checkOutput();
    spiByte(8'h5A);
    csHigh();
    checkOutput();
    for (int a = 0; a < N; a++) readPixel(a);
    csLow();
    checkOutput();
    csHigh();

    csLow();
    for (int i = 0; i < 5; i++) spiBit(i[0]);
    applyReset(3);
    checkOutput();
    for (int a = 0; a < N; a++) readPixel(a);
    applyStimulus(FRAME_BYTES, 1'b1, 8'h80);
    checkOutput();
    for (int a = 0; a < N; a++) readPixel(a);

    for (int t = 0; t < 30; t++) begin
      int n, reads;
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FRAME_BYTES + 3) : FRAME_BYTES;
      applyStimulus(n, 1'b0, 8'h00);
      checkOutput();
      reads = $urandom_range(0, 4);
      for (int r = 0; r < reads; r++)
        readPixel($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, N - 1));
    end

    for (int w = 0; w < 20 && expQ.size() != 0; w++) @(negedge clk);
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d responses outstanding, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_pixel_buffer.md
Name: spi_pixel_buffer

Overview:
- Upstream feeder for the ws2812 chain driver.
- Receives pixel data from an SPI master (mode 0, MSB first) and stores it in a shadow bank of NUM_LEDS 24-bit RGB entries.
- On completion of a full frame, swaps the shadow bank with the active bank at the start of the next output frame, so the LED chain never shows a torn frame.
- Serves the driver's data_request/address pull interface from the active bank.

Parameters:
- NUM_LEDS, 4, number of pixels per frame; must be >= 2.
- ADDR_W, $clog2(NUM_LEDS), pixel address width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock; asynchronous to clk.
- spi_mosi  in  1  SPI data; asynchronous to clk.
- spi_cs_n  in  1  SPI chip select, active low; asynchronous to clk.
- data_request  in  1  driver strobe; pixel is read at this cycle's address.
- address  in  ADDR_W  driver's current LED index.
- red_out  out  8  red byte for the requested pixel.
- green_out  out  8  green byte for the requested pixel.
- blue_out  out  8  blue byte for the requested pixel.
- frame_done  out  1  one-cycle pulse when a complete frame is latched into the shadow bank.
- overflow  out  1  sticky flag: bytes were received beyond NUM_LEDS*3 in the current transaction.

Behaviour:
Clocking and reset
- Single clock domain (clk); reset is synchronous and active-high.
- Reset values: red_out/green_out/blue_out = 0, frame_done = 0, overflow = 0.
- Reset also clears: bank_sel = 0, swap_pending = 0, both banks = 0, receive FSM = IDLE.
- Reset asserted mid-transaction discards all received data.

Input synchronisation
- spi_sclk: 3-flop synchroniser; the rising edge is detected on stages 2/3.
- spi_mosi and spi_cs_n: 2-flop synchronisers.
- clk must be >= 4x the SCLK frequency.

Receive FSM states
- IDLE: wait for synchronised cs_n == 0. On entry to a transaction, clear bit_cnt, color_cnt, pix_addr and overflow.
- SHIFT: on each SCLK rising edge, shift mosi into byte_sr (MSB first) and increment bit_cnt (3 bits). When the 8th bit arrives, go to STORE.
- STORE: one cycle. Byte order per pixel is R, G, B.
  - Hold R and G in staging registers.
  - On B, write {R,G,B} to shadow[pix_addr], then increment pix_addr.
  - If pix_addr was NUM_LEDS-1: set frame_complete and pulse frame_done.
  - Return to SHIFT.
  - Bytes arriving after frame_complete are not written; instead set overflow.
- Synchronised cs_n rising, in any state, returns the FSM to IDLE.
  - A partial byte or partial pixel is discarded.
  - If frame_complete was set: set swap_pending and clear frame_complete.
  - Otherwise the shadow bank is left partially written but is never displayed.

Bank swap
- When data_request && address == 0 && swap_pending: toggle bank_sel and clear swap_pending in the same cycle.
- The read in that same cycle already uses the new active bank.
- If a second frame completes before the swap, it simply re-sets swap_pending; the shadow bank holds the latest data.
- Shadow writes go to bank !bank_sel.

Read path
- When data_request == 1: on the next clk edge, {red_out, green_out, blue_out} <= active[address]. Latency is 1 cycle, matching the driver's sample point.
- When data_request == 0: outputs hold their value.
- address >= NUM_LEDS returns 0.

Simultaneous events
- A shadow write and an active-bank read in the same cycle never conflict, because they target different banks.
- A swap and a cs_n-rising event in the same cycle: the swap uses the old swap_pending, and the new pending flag is set afterwards.

Decomposition:
- Shared package ws2812_pkg:
  - pixel_t (a 24-bit {r,g,b} struct)
  - color index constants COLOR_R=0, COLOR_G=1, COLOR_B=2
  - BYTES_PER_PIXEL=3
- Sub-module spi_sync_edge: synchronises sclk/mosi/cs_n and outputs sclk_rise, mosi_s, cs_n_s, cs_rise, cs_fall.
- Bank storage and FSM stay in the top level.

Test Plan:
- Reset, then pulse data_request with address=0..3 -> all outputs 0; overflow=0, frame_done=0.
- Send 12 bytes 0x11..0x1C with CS low, raise CS, then pulse data_request at addr 0, then addr 2 -> frame_done pulses once. Addr 0 reads R=11 G=12 B=13; addr 2 reads R=17 G=18 B=19.
- Send 12 bytes without yet issuing data_request at addr 0 -> a read at addr 1 (no prior addr-0 request) returns the old data 0; after a request at addr 0, addr 1 reads 14/15/16.
- Send 7 bytes, then raise CS -> no frame_done, no swap; reads keep the previous frame.
- Send 14 bytes -> overflow=1 after the 13th byte; frame still swaps; overflow clears on the next CS fall.
- Assert reset mid-byte (after 5 SCLK edges) -> FSM returns to IDLE; the next full 12-byte frame is received correctly.
